// File: rtl/avalon_lsu_master_if.sv
// Bundle of the CPU request/response handshake and the Avalon-MM master bus
// used by avalon_lsu_master; master = LSU side, slave = CPU/RAM side.
interface avalon_lsu_master_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic        waitrequest;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata;

  modport master (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
           waitrequest, readdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
           address, read, write, writedata, byteenable
  );

  modport slave (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
           waitrequest, readdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           address, read, write, writedata, byteenable
  );
endinterface

// File: rtl/avalon_lsu_master.sv
// Load/store unit issuing single Avalon-MM transactions to a 32-bit RAM.
// Optional bus-stall timeout enabled by defining AVL_TIMEOUT_EN.
//
// state | meaning
// IDLE  | req_ready high, waiting for a CPU request
// BUS   | Avalon read/write asserted, held while waitrequest is high
// RESP  | one-cycle resp_valid pulse, then back to IDLE
module avalon_lsu_master #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic                  clk,
  input logic                  rst,
  avalon_lsu_master_if.master  bus
);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t      state, state_n;
  logic [31:0] address_q, address_n;
  logic [31:0] writedata_q, writedata_n;
  logic [31:0] rdata_q, rdata_n;
  logic [3:0]  be_q, be_n;
  logic        read_q, read_n;
  logic        write_q, write_n;
  logic        ready_q, ready_n;
  logic        rvalid_q, rvalid_n;
  logic        err_q, err_n;
  logic [1:0]  size_q, size_n;
  logic [1:0]  off_q, off_n;
  logic        sign_q, sign_n;
  logic        misaligned;

`ifdef AVL_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_n;
`endif

  function automatic logic [3:0] lanes(logic [1:0] sz, logic [1:0] off);
    case (sz)
      2'b00:   lanes = 4'b0001 << off;
      2'b01:   lanes = off[1] ? 4'b1100 : 4'b0011;
      default: lanes = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] replicate(logic [1:0] sz, logic [31:0] d);
    case (sz)
      2'b00:   replicate = {4{d[7:0]}};
      2'b01:   replicate = {2{d[15:0]}};
      default: replicate = d;
    endcase
  endfunction

  // Shift the addressed lane(s) down to bit 0 before extending.
  function automatic logic [31:0] extract(logic [31:0] d, logic [1:0] sz,
                                          logic [1:0] off, logic sg);
    logic [31:0] sh;
    sh = d >> {off, 3'b000};
    case (sz)
      2'b00:   extract = {{24{sg & sh[7]}}, sh[7:0]};
      2'b01:   extract = {{16{sg & sh[15]}}, sh[15:0]};
      default: extract = d;
    endcase
  endfunction

  assign misaligned = (bus.req_size == 2'b11)
                    | ((bus.req_size == 2'b01) & bus.req_addr[0])
                    | ((bus.req_size == 2'b10) & (|bus.req_addr[1:0]));

  always_comb begin
    state_n     = state;
    address_n   = address_q;
    writedata_n = writedata_q;
    be_n        = be_q;
    read_n      = read_q;
    write_n     = write_q;
    ready_n     = ready_q;
    size_n      = size_q;
    off_n       = off_q;
    sign_n      = sign_q;
    rvalid_n    = 1'b0;
    err_n       = 1'b0;
    rdata_n     = '0;
`ifdef AVL_TIMEOUT_EN
    cnt_n       = cnt_q;
`endif
    case (state)
      IDLE: begin
        if (bus.req_valid && ready_q) begin
          ready_n = 1'b0;
          size_n  = bus.req_size;
          off_n   = bus.req_addr[1:0];
          sign_n  = bus.req_signed;
          if (misaligned) begin
            state_n  = RESP;
            rvalid_n = 1'b1;
            err_n    = 1'b1;
          end else begin
            state_n     = BUS;
            address_n   = {bus.req_addr[31:2], 2'b00};
            read_n      = !bus.req_write;
            write_n     = bus.req_write;
            be_n        = lanes(bus.req_size, bus.req_addr[1:0]);
            writedata_n = replicate(bus.req_size, bus.req_wdata);
`ifdef AVL_TIMEOUT_EN
            cnt_n       = '0;
`endif
          end
        end
      end
      BUS: begin
        if (!bus.waitrequest) begin
          read_n   = 1'b0;
          write_n  = 1'b0;
          state_n  = RESP;
          rvalid_n = 1'b1;
          if (read_q) rdata_n = extract(bus.readdata, size_q, off_q, sign_q);
        end
`ifdef AVL_TIMEOUT_EN
        // This edge closes the TIMEOUT_CYCLES-th stall cycle.
        else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          read_n   = 1'b0;
          write_n  = 1'b0;
          state_n  = RESP;
          rvalid_n = 1'b1;
          err_n    = 1'b1;
        end else begin
          cnt_n = cnt_q + 1'b1;
        end
`endif
      end
      RESP: begin
        state_n = IDLE;
        ready_n = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      address_q   <= '0;
      writedata_q <= '0;
      be_q        <= '0;
      read_q      <= 1'b0;
      write_q     <= 1'b0;
      ready_q     <= 1'b1;
      rvalid_q    <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      size_q      <= '0;
      off_q       <= '0;
      sign_q      <= 1'b0;
`ifdef AVL_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state       <= state_n;
      address_q   <= address_n;
      writedata_q <= writedata_n;
      be_q        <= be_n;
      read_q      <= read_n;
      write_q     <= write_n;
      ready_q     <= ready_n;
      rvalid_q    <= rvalid_n;
      err_q       <= err_n;
      rdata_q     <= rdata_n;
      size_q      <= size_n;
      off_q       <= off_n;
      sign_q      <= sign_n;
`ifdef AVL_TIMEOUT_EN
      cnt_q       <= cnt_n;
`endif
    end
  end

  assign bus.req_ready  = ready_q;
  assign bus.resp_valid = rvalid_q;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
  assign bus.address    = address_q;
  assign bus.read       = read_q;
  assign bus.write      = write_q;
  assign bus.writedata  = writedata_q;
  assign bus.byteenable = be_q;

endmodule

// File: tb/tb_avalon_lsu_master.sv
// Scoreboard bench for avalon_lsu_master: random requests against a lane/byte model,
// separate bus and response monitors, plus reset and stall/timeout scenarios.
module tb_avalon_lsu_master;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  avalon_lsu_master_if bus();
  avalon_lsu_master #(.TIMEOUT_CYCLES(TO)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        rd;
    int          cycles;
  } bus_exp_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          at;
  } resp_exp_t;

  bus_exp_t    bus_q[$];
  resp_exp_t   resp_q[$];
  int          cur_waits = 0;
  logic [31:0] cur_rdata = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: lane count from size, byte offset from addr mod 4.
  function automatic void model(input logic w, input logic [1:0] sz, input logic sg,
                                input logic [31:0] addr, input logic [31:0] wd,
                                input logic [31:0] rd, output logic err,
                                output logic [3:0] be, output logic [31:0] wexp,
                                output logic [31:0] rexp);
    int nb, off;
    logic [31:0] mask, v;
    off = int'(addr % 32'd4);
    err = (sz == 2'd3);
    nb  = err ? 1 : (1 << sz);
    if (!err && (off % nb) != 0) err = 1'b1;
    be = 4'(((1 << nb) - 1) << off);
    for (int i = 0; i < 4; i++) wexp[8*i +: 8] = wd[8*(i % nb) +: 8];
    mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*nb)) - 32'd1);
    v = (rd >> (8*off)) & mask;
    if (sg && nb < 4 && v[8*nb-1]) v = v | ~mask;
    rexp = (w || err) ? 32'd0 : v;
  endfunction

  task automatic do_req(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] rd, input int waits);
    int n = 0;
    int a;
    logic err, timed;
    logic [3:0] be;
    logic [31:0] wexp, rexp;
    while (!bus.req_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_wait", 32'(bus.req_ready), 32'd1);
    if (!bus.req_ready) return;
    model(w, sz, sg, addr, wd, rd, err, be, wexp, rexp);
    a = cyc + 1;
    if (err) begin
      resp_q.push_back('{rdata: 32'd0, err: 1'b1, at: a});
    end else begin
`ifdef AVL_TIMEOUT_EN
      timed = (waits >= TO);
`else
      timed = 1'b0;
`endif
      bus_q.push_back('{addr: addr & ~32'd3, be: be, wdata: wexp, rd: !w,
                        cycles: timed ? TO : waits + 1});
      resp_q.push_back('{rdata: timed ? 32'd0 : rexp, err: timed,
                         at: timed ? a + TO : a + 1 + waits});
    end
    cur_waits      = waits;
    cur_rdata      = rd;
    bus.req_write  = w;
    bus.req_size   = sz;
    bus.req_signed = sg;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    bus.req_valid  = 1'b1;
    @(negedge clk);
    bus.req_valid  = 1'b0;
    bus.req_addr   = $urandom;
    bus.req_wdata  = $urandom;
  endtask

  // Slave: stalls cur_waits cycles, then presents cur_rdata; garbage otherwise.
  initial begin
    bit in_txn = 0;
    int wait_left = 0;
    bus.waitrequest = 1'b0;
    bus.readdata    = $urandom;
    forever begin
      @(negedge clk);
      if (rst) in_txn = 0;
      else if ((bus.read || bus.write) && !in_txn) begin
        in_txn    = 1;
        wait_left = cur_waits;
      end else if (!(bus.read || bus.write)) in_txn = 0;
      if (in_txn && wait_left > 0) begin
        bus.waitrequest = 1'b1;
        wait_left--;
        bus.readdata = $urandom;
      end else begin
        bus.waitrequest = 1'b0;
        bus.readdata    = in_txn ? cur_rdata : $urandom;
      end
    end
  end

  initial begin
    bit on = 0;
    int n = 0;
    bus_exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        on = 0;
        continue;
      end
      if (bus.read || bus.write) begin
        chk("rw_exclusive", 32'(bus.read & bus.write), 32'd0);
        if (!on) begin
          chk("bus_expected", 32'(bus_q.size() != 0), 32'd1);
          if (bus_q.size() != 0) begin
            e  = bus_q.pop_front();
            on = 1;
            n  = 0;
          end
        end
        if (on) begin
          chk("address", bus.address, e.addr);
          chk("byteenable", 32'(bus.byteenable), 32'(e.be));
          chk("read", 32'(bus.read), 32'(e.rd));
          chk("write", 32'(bus.write), 32'(!e.rd));
          if (!e.rd) chk("writedata", bus.writedata, e.wdata);
          n++;
        end
      end else if (on) begin
        chk("bus_cycles", n, e.cycles);
        on = 0;
      end
    end
  end

  initial begin
    resp_exp_t r;
    forever begin
      @(negedge clk);
      if (!rst && bus.resp_valid) begin
        chk("resp_expected", 32'(resp_q.size() != 0), 32'd1);
        if (resp_q.size() != 0) begin
          r = resp_q.pop_front();
          chk("resp_rdata", bus.resp_rdata, r.rdata);
          chk("resp_err", 32'(bus.resp_err), 32'(r.err));
          chk("resp_latency", cyc, r.at);
          chk("ready_low_in_resp", 32'(bus.req_ready), 32'd0);
        end
      end
    end
  end

  initial begin
    logic [1:0]  sz;
    logic [31:0] addr;
    int n;
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_size   = 2'd0;
    bus.req_signed = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;

    #1 rst = 1'b1;
    #1;
    chk("rst_read", 32'(bus.read), 32'd0);
    chk("rst_write", 32'(bus.write), 32'd0);
    chk("rst_address", bus.address, 32'd0);
    chk("rst_writedata", bus.writedata, 32'd0);
    chk("rst_byteenable", 32'(bus.byteenable), 32'd0);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
    chk("rst_resp_err", 32'(bus.resp_err), 32'd0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    do_req(1'b0, 2'd2, 1'b0, 32'h8, 32'h0, 32'h1234_5678, 0);
    do_req(1'b0, 2'd0, 1'b1, 32'h7, 32'h0, 32'h80FF_0000, 0);
    do_req(1'b0, 2'd0, 1'b0, 32'h7, 32'h0, 32'h80FF_0000, 0);
    do_req(1'b1, 2'd1, 1'b0, 32'h6, 32'hAAAA_5678, $urandom, 3);
    do_req(1'b0, 2'd2, 1'b0, 32'h2, 32'h0, $urandom, 0);
    do_req(1'b0, 2'd1, 1'b0, 32'h5, 32'h0, $urandom, 0);

    for (int i = 0; i < 300; i++) begin
      sz   = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      addr = $urandom;
      if (sz != 2'd3 && $urandom_range(0, 3) != 0) addr = addr & ~((32'd1 << sz) - 32'd1);
      do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), addr, $urandom,
             $urandom, $urandom_range(0, 3));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

`ifdef AVL_TIMEOUT_EN
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, $urandom, 1000);
`endif
    do_req(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, $urandom, 1000);
`ifdef AVL_TIMEOUT_EN
    repeat (3) @(negedge clk);
`else
    repeat (100) @(negedge clk);
    chk("read_held_no_timeout", 32'(bus.read), 32'd1);
`endif
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_bus_read", 32'(bus.read), 32'd0);
    chk("rst_mid_bus_write", 32'(bus.write), 32'd0);
    resp_q.delete();
    bus_q.delete();
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 32'(bus.req_ready), 32'd1);
    chk("no_resp_after_rst", 32'(bus.resp_valid), 32'd0);
    do_req(1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 32'hCAFE_F00D, 0);

    n = 0;
    while ((resp_q.size() != 0 || bus_q.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_resp", resp_q.size(), 32'd0);
    chk("drain_bus", bus_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/avalon_lsu_master.md
Name: avalon_lsu_master

Overview:
Load/store unit that converts CPU memory requests (byte/half/word, signed/unsigned loads, stores) into single Avalon-MM master transactions toward the 32-bit RAM slave (RAM_32x64k_avalon). It sits directly upstream of the RAM, between the CPU datapath and the Avalon bus. It computes the word-aligned address, the byte lanes and the replicated write data, holds the bus while waitrequest is high, and returns extracted, extended load data as a one-cycle response.

Parameters:
TIMEOUT_CYCLES, 64, bus-stall limit in cycles; used only when AVL_TIMEOUT_EN is defined.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous active-high reset.
req_valid  in  1  CPU request present.
req_ready  out  1  high only in IDLE; a request is accepted at a posedge with req_valid & req_ready.
req_write  in  1  1 = store, 0 = load.
req_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
req_signed  in  1  sign-extend loads (ignored for word and store).
req_addr  in  32  byte address.
req_wdata  in  32  store data, right-justified.
resp_valid  out  1  one-cycle completion pulse.
resp_rdata  out  32  extended load data; 0 for stores and errors.
resp_err  out  1  valid with resp_valid.
address  out  32  Avalon byte address, bits[1:0] always 0.
read  out  1  Avalon read.
write  out  1  Avalon write.
waitrequest  in  1  slave stall.
writedata  out  32  Avalon write data.
byteenable  out  4  lane k covers bits 8k+7:8k.
readdata  in  32  Avalon read data, valid in the cycle waitrequest is low.

Behaviour:
- Reset values: state IDLE; read=0, write=0, address=0, writedata=0, byteenable=0; resp_valid=0, resp_rdata=0, resp_err=0; req_ready=1. All outputs are registered.
- FSM states are IDLE, BUS and RESP.
- IDLE -> BUS on acceptance of an aligned request.
- IDLE -> RESP with err=1 on acceptance of a misaligned request: half with addr[0]=1, word with addr[1:0]!=0, or size 11. No bus cycle is issued in this case.
- BUS: address = {req_addr[31:2],2'b00}; read = !req_write; write = req_write.
- BUS byte lanes: byte -> byteenable = 1<<addr[1:0]; half -> 0011 or 1100 selected by addr[1]; word -> 1111.
- BUS writedata: byte replicated in all four lanes, half replicated in both halves, word unchanged.
- All bus outputs are held stable while waitrequest=1.
- On the posedge where waitrequest=0, the transaction completes. Read and write drop to 0 in the next cycle, and the state moves to RESP.
- On a load, the addressed lane(s) of readdata are captured, shifted to bit 0, and sign- or zero-extended.
- RESP: resp_valid=1 for exactly one cycle, then the state returns to IDLE and req_ready=1 again.
- Latency: accept at edge 0; bus asserted in cycle 1; with zero wait, resp_valid is high in cycle 2. Each wait cycle adds 1.
- Back-to-back: a new request can be accepted on the edge after resp_valid, giving a 3-cycle minimum issue interval.
- Reset asserted mid-BUS or mid-RESP: read and write clear immediately (asynchronously), any pending response is discarded, and the FSM enters IDLE.
- read and write are never high in the same cycle.
- Bus data is ignored outside BUS.

Optional Feature:
AVL_TIMEOUT_EN
- Defined: a counter clears on entry to BUS and increments each cycle waitrequest=1. When it reaches TIMEOUT_CYCLES, the FSM drops read and write, goes to RESP, and returns resp_err=1 with resp_rdata=0.
- Undefined: there is no counter, and the unit waits indefinitely.

Test Plan:
1. Word load at addr 0x8; slave returns readdata 0x12345678 with no wait -> address 0x8, byteenable 1111, read high for 1 cycle, resp_valid 2 cycles after accept, resp_rdata 0x12345678, err 0.
2. Byte loads at addr 0x7 with readdata 0x80FF0000 -> byteenable 1000. Signed gives 0xFFFFFF80; unsigned gives 0x00000080.
3. Half store at addr 0x6, wdata 0xAAAA5678, waitrequest high 3 cycles -> address 0x4, byteenable 1100, writedata 0x56785678, outputs stable for 4 cycles, then a resp_valid pulse with rdata 0.
4. Misaligned word load at addr 0x2, then half load at 0x5 -> read never asserted; each gives resp_valid with resp_err 1 one cycle after accept.
5. Reset pulse during BUS (waitrequest held high) -> read=0 immediately, no resp_valid, req_ready=1 after release; a following word load at 0x0 completes normally.
6. With AVL_TIMEOUT_EN and TIMEOUT_CYCLES=8, waitrequest stuck at 1 -> read drops after 8 stall cycles and resp_err=1. Without the macro, read is still high after 100 cycles.
